divider_seq: RTL and testbench

- Iterative radix-2 restoring divider, one quotient bit per clock.
- Inverse companion of the multiplier: divides a 2*DATA_LENGTH dividend (product-width) by a DATA_LENGTH divisor, giving quotient and remainder.
- Uses the same start/busy/finish handshake as the multiplier, so the two are interchangeable on the arithmetic datapath.

---
 rtl/divider_pkg.sv | 13 +
 rtl/divider_step.sv | 23 ++
 rtl/divider_seq.sv | 167 ++++++++++++++++
 tb/tb_divider_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package divider_pkg;

  localparam int DATA_LENGTH = 32;
  localparam int CNT_WIDTH   = $clog2(2 * DATA_LENGTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module divider_step #(
  parameter int DATA_LENGTH = 32
) (
  input  logic [DATA_LENGTH:0]   rem_i,
  input  logic                   dvd_bit_i,
  input  logic [DATA_LENGTH-1:0] divisor_i,
  output logic [DATA_LENGTH:0]   rem_o,
  output logic                   q_bit_o
);

  logic [DATA_LENGTH:0] shifted;
  logic [DATA_LENGTH:0] diff;

  always_comb begin
    shifted = {rem_i[DATA_LENGTH-1:0], dvd_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    // A set top bit means the true shifted value overflowed and is certainly >= divisor.
    q_bit_o = rem_i[DATA_LENGTH] || (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff : shifted;
  end

endmodule

// File: rtl/divider_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/finish handshake.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement (truncating) division.
module divider_seq #(
  parameter int DATA_LENGTH = divider_pkg::DATA_LENGTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     finish_o,
  input  logic [2*DATA_LENGTH-1:0] dividend_i,
  input  logic [DATA_LENGTH-1:0]   divisor_i,
  output logic [2*DATA_LENGTH-1:0] quotient_o,
  output logic [DATA_LENGTH-1:0]   remainder_o,
  output logic                     div_by_zero_o
);
  import divider_pkg::*;

  localparam int                 QW      = 2 * DATA_LENGTH;
  localparam int                 CNT_W   = $clog2(QW);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(QW - 1);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_LENGTH:0]   rem_q, rem_d;
  logic [QW-1:0]          dvd_q, dvd_d;
  logic [DATA_LENGTH-1:0] dsr_q, dsr_d;
  logic [QW-1:0]          quot_q, quot_d;
  logic [DATA_LENGTH-1:0] remo_q, remo_d;
  logic                   dbz_q, dbz_d;
  logic                   fin_q, fin_d;

  logic [DATA_LENGTH:0]   step_rem;
  logic                   step_q;
  logic [QW-1:0]          dvd_nxt;

`ifdef DIVIDER_SIGNED_EN
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;

  function automatic logic [QW-1:0] neg_if_q(input logic [QW-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_LENGTH-1:0] neg_if_r(input logic [DATA_LENGTH-1:0] v,
                                                      input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
`endif

  divider_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .rem_i    (rem_q),
    .dvd_bit_i(dvd_q[QW-1]),
    .divisor_i(dsr_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign dvd_nxt = {dvd_q[QW-2:0], step_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    fin_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = dividend_i[DATA_LENGTH-1:0];
            dbz_d   = 1'b1;
            fin_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_MAX;
            rem_d   = '0;
            dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_d  = dividend_i[QW-1] ^ divisor_i[DATA_LENGTH-1];
            rneg_d  = dividend_i[QW-1];
            dvd_d   = neg_if_q(dividend_i, dividend_i[QW-1]);
            dsr_d   = neg_if_r(divisor_i, divisor_i[DATA_LENGTH-1]);
`else
            dvd_d   = dividend_i;
            dsr_d   = divisor_i;
`endif
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          fin_d   = 1'b1;
`ifdef DIVIDER_SIGNED_EN
          quot_d  = neg_if_q(dvd_nxt, qneg_q);
          remo_d  = neg_if_r(step_rem[DATA_LENGTH-1:0], rneg_q);
`else
          quot_d  = dvd_nxt;
          remo_d  = step_rem[DATA_LENGTH-1:0];
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      fin_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      fin_q   <= fin_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign finish_o      = fin_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = remo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: an 8-bit instance for the main vectors, a 32-bit one for round trips.
module tb_divider_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, busy8, fin8, dbz8;
  logic [15:0] dvd8, q8;
  logic [7:0]  dsr8, r8;

  logic        start32, busy32, fin32, dbz32;
  logic [63:0] dvd32, q32;
  logic [31:0] dsr32, r32;

  int n_tests = 0;
  int n_fail  = 0;

  divider_seq #(.DATA_LENGTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .busy_o(busy8), .finish_o(fin8),
    .dividend_i(dvd8), .divisor_i(dsr8), .quotient_o(q8), .remainder_o(r8),
    .div_by_zero_o(dbz8)
  );

  divider_seq #(.DATA_LENGTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .busy_o(busy32), .finish_o(fin32),
    .dividend_i(dvd32), .divisor_i(dsr32), .quotient_o(q32), .remainder_o(r32),
    .div_by_zero_o(dbz32)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // inject >= 0 drives a junk start pulse that many cycles into the run.
  task automatic run8(input string tag, input logic [15:0] a, input logic [7:0] b,
                      input int inject, input int exp_cyc, input logic [15:0] eq,
                      input logic [7:0] er, input logic edbz);
    int cyc = 0;
    dvd8 = a; dsr8 = b; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    check({tag, "_busy"}, 64'(busy8), 64'd1);
    if (b != 8'h00) check({tag, "_dbzclr"}, 64'(dbz8), 64'd0);
    while (!fin8 && cyc < 100) begin
      if (cyc == inject) begin
        start8 = 1'b1; dvd8 = 16'hFFFF; dsr8 = 8'h01;
      end
      tick;
      start8 = 1'b0;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_q"}, 64'(q8), 64'(eq));
    check({tag, "_r"}, 64'(r8), 64'(er));
    check({tag, "_dbz"}, 64'(dbz8), 64'(edbz));
    tick;
    check({tag, "_pulse"}, 64'(fin8), 64'd0);
    check({tag, "_idle"}, 64'(busy8), 64'd0);
  endtask

  task automatic run32(input logic [63:0] a, input logic [31:0] b, input logic [63:0] eq);
    int cyc = 0;
    dvd32 = a; dsr32 = b; start32 = 1'b1;
    tick;
    start32 = 1'b0;
    while (!fin32 && cyc < 200) begin
      tick;
      cyc++;
    end
    check("rt32_lat", 64'(cyc), 64'd64);
    check("rt32_q", q32, eq);
    check("rt32_r", 64'(r32), 64'd0);
    tick;
  endtask

  initial begin
    int fin_seen;
    int t, first, second;
    logic [31:0] a, b;
    logic [63:0] p;

    rst = 1'b1;
    start8 = 1'b0; dvd8 = '0; dsr8 = '0;
    start32 = 1'b0; dvd32 = '0; dsr32 = '0;
    repeat (3) tick;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_fin", 64'(fin8), 64'd0);
    check("rst_q", 64'(q8), 64'd0);
    check("rst_r", 64'(r8), 64'd0);
    check("rst_dbz", 64'(dbz8), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    rst = 1'b0;
    tick;

    run8("d3039", 16'h3039, 8'h07, -1, 16, 16'h06E3, 8'h04, 1'b0);

    // Abort a run with reset; outputs from the previous result must clear.
    dvd8 = 16'h3039; dsr8 = 8'h07; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_fin", 64'(fin8), 64'd0);
    check("abort_q", 64'(q8), 64'd0);
    check("abort_r", 64'(r8), 64'd0);
    fin_seen = 0;
    repeat (20) begin
      tick;
      if (fin8) fin_seen++;
    end
    check("abort_nofin", 64'(fin_seen), 64'd0);

    run8("d0064", 16'h0064, 8'h0A, -1, 16, 16'h000A, 8'h00, 1'b0);
    run8("rt26ac", 16'h26AC, 8'h3C, -1, 16, 16'h00A5, 8'h00, 1'b0);
    run8("dzero", 16'h1234, 8'h00, -1, 0, 16'hFFFF, 8'h34, 1'b1);
    run8("small", 16'h0005, 8'h09, 4, 16, 16'h0000, 8'h05, 1'b0);

    // start_i held high: back-to-back operations, one IDLE cycle between.
    dvd8 = 16'h0064; dsr8 = 8'h0A; start8 = 1'b1;
    tick;
    t = 0; first = -1; second = -1;
    while (second < 0 && t < 200) begin
      if (fin8) begin
        if (first < 0) first = t;
        else second = t;
      end
      if (second < 0) begin
        tick;
        t++;
      end
    end
    start8 = 1'b0;
    check("b2b_first", 64'(first), 64'd16);
    check("b2b_gap", 64'(second - first), 64'd18);
    check("b2b_q", 64'(q8), 64'h000A);
    tick;
    tick;

`ifdef DIVIDER_SIGNED_EN
    run8("sneg", 16'hFF9C, 8'h07, -1, 16, 16'hFFF2, 8'hFE, 1'b0);
    run8("smin", 16'h8000, 8'hFF, -1, 16, 16'h8000, 8'h00, 1'b0);
`endif

    // Multiplier round trip; operands kept non-negative so the signed build agrees.
    for (int i = 0; i < 100; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      b = ($urandom & 32'h7FFF_FFFF) | 32'h1;
      p = 64'(a) * 64'(b);
      run32(p, b, 64'(a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
